// File: rtl/h264unbuffer_inter.sv
// Decoder-side coefficient buffer: collects sparse CAVLC levels into one of two
// ping-pong 4x4 banks and streams each completed block out in zigzag order.
module h264unbuffer_inter #(
  parameter int unsigned DW    = 12,
  parameter int unsigned NBANK = 2
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          NEWSLICE,
  input  logic          VALIDI,
  input  logic [DW-1:0] ZIN,
  input  logic [3:0]    ZPOS,
  input  logic [1:0]    BTYPE,
  input  logic          BEND,
  output logic          READYI,
  output logic [DW-1:0] VOUT,
  output logic          VALIDO,
  output logic          OFIRST,
  output logic [1:0]    OTYPE,
  output logic [4:0]    OTOTAL,
  input  logic          READYO,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  logic [DW-1:0] data_q [NBANK][16];
  logic [15:0]   mask_q [NBANK];
  logic [1:0]    type_q [NBANK];
  logic [4:0]    cnt_q  [NBANK];
  logic [NBANK-1:0] full_q;
  logic          wbank_q, rbank_q, nbank, wbusy_q, err_q;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d, last_q, last_d;
  logic [DW-1:0] vout_q, vout_d;
  logic          valido_q, valido_d, ofirst_q, ofirst_d;
  logic [1:0]    otype_q, otype_d;
  logic [4:0]    ototal_q, ototal_d;

  logic          wr_acc, wr_en, pos_bad, bend_acc, old_nz, err_set, out_ld, drain;
  logic [4:0]    cnt_wr;
  logic [1:0]    rtype;

  function automatic logic [3:0] first_idx(input logic [1:0] t);
    return (t == 2'd2) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] t);
    return (t == 2'd1) ? 4'd3 : 4'd15;
  endfunction

  assign nbank    = ~rbank_q;
  assign READYI   = ~full_q[wbank_q];
  assign wr_acc   = VALIDI && READYI;
  assign pos_bad  = ((BTYPE == 2'd1) && (ZPOS > 4'd3)) || ((BTYPE == 2'd2) && (ZPOS == 4'd0));
  assign wr_en    = wr_acc && !pos_bad;
  assign bend_acc = BEND && READYI;
  // A rewrite retracts the old value's contribution before adding the new one.
  assign old_nz   = mask_q[wbank_q][ZPOS] && (data_q[wbank_q][ZPOS] != '0);
  assign cnt_wr   = cnt_q[wbank_q] - {4'd0, old_nz} + {4'd0, (ZIN != '0)};
  assign err_set  = (wr_acc && pos_bad) || (bend_acc && (BTYPE == 2'd3)) ||
                    ((VALIDI || BEND) && !READYI);
  assign rtype    = type_q[rbank_q];
  assign out_ld   = !valido_q || READYO;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    vout_d   = vout_q;
    valido_d = valido_q;
    ofirst_d = ofirst_q;
    otype_d  = otype_q;
    ototal_d = ototal_q;
    drain    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valido_q && READYO) valido_d = 1'b0;
        if (full_q[rbank_q]) begin
          state_d = StEmit;
          idx_d   = first_idx(rtype);
          last_d  = last_idx(rtype);
        end
      end
      StEmit: begin
        if (out_ld) begin
          valido_d = 1'b1;
          vout_d   = mask_q[rbank_q][idx_q] ? data_q[rbank_q][idx_q] : '0;
          ofirst_d = (idx_q == first_idx(rtype));
          otype_d  = rtype;
          ototal_d = cnt_q[rbank_q];
          idx_d    = idx_q + 4'd1;
          if (idx_q == last_q) begin
            drain = 1'b1;
            // Chain straight into the other bank when it is already waiting.
            if (full_q[nbank]) begin
              idx_d  = first_idx(type_q[nbank]);
              last_d = last_idx(type_q[nbank]);
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en) data_q[wbank_q][ZPOS] <= ZIN;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN || NEWSLICE) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      last_q   <= '0;
      vout_q   <= '0;
      valido_q <= 1'b0;
      ofirst_q <= 1'b0;
      otype_q  <= '0;
      ototal_q <= '0;
      full_q   <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      wbusy_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned b = 0; b < NBANK; b++) begin
        mask_q[b] <= '0;
        type_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      vout_q   <= vout_d;
      valido_q <= valido_d;
      ofirst_q <= ofirst_d;
      otype_q  <= otype_d;
      ototal_q <= ototal_d;
      err_q    <= err_q | err_set;
      if (drain) begin
        full_q[rbank_q] <= 1'b0;
        mask_q[rbank_q] <= '0;
        cnt_q[rbank_q]  <= '0;
        rbank_q         <= nbank;
      end
      if (wr_en) begin
        mask_q[wbank_q][ZPOS] <= 1'b1;
        cnt_q[wbank_q]        <= cnt_wr;
      end
      if (wr_acc) wbusy_q <= 1'b1;
      if (bend_acc) begin
        full_q[wbank_q] <= 1'b1;
        type_q[wbank_q] <= (BTYPE == 2'd3) ? 2'd0 : BTYPE;
        wbank_q         <= ~wbank_q;
        wbusy_q         <= 1'b0;
      end
    end
  end

  assign VOUT   = vout_q;
  assign VALIDO = valido_q;
  assign OFIRST = ofirst_q;
  assign OTYPE  = otype_q;
  assign OTOTAL = ototal_q;
  assign ERR    = err_q;
  assign DONE   = ~|full_q && !valido_q && !wbusy_q;

endmodule

// File: doc/h264unbuffer_inter.md
Name: h264unbuffer_inter

Overview:
Decoder-side coefficient buffer. It takes levels from the CAVLC decoder, which arrive per 4x4 block in arbitrary position order (highest frequency first, sparse) with explicit zigzag position. It zero-fills the missing positions and streams each block out in forward zigzag order to the inverse-quant/transform path. Two ping-pong block banks let one block fill while the previous one drains.

Parameters:
DW, 12, coefficient width
NBANK, 2, number of block banks (fixed at 2; other values are unsupported)

Ports:
CLK  in  1  clock, all logic on rising edge
RESETN  in  1  synchronous active-low reset
NEWSLICE  in  1  synchronous flush, same effect as reset
VALIDI  in  1  input coefficient strobe
ZIN  in  DW  coefficient level (signed two's complement)
ZPOS  in  4  zigzag position of ZIN within the block
BTYPE  in  2  block type, sampled with BEND: 0 luma (16 coeff, pos 0..15), 1 chroma DC (4 coeff, pos 0..3), 2 chroma AC (15 coeff, pos 1..15), 3 reserved
BEND  in  1  end-of-block strobe; may coincide with the last VALIDI
READYI  out  1  write bank free; VALIDI/BEND are accepted only when high
VOUT  out  DW  output coefficient
VALIDO  out  1  VOUT valid
OFIRST  out  1  high with the first coefficient of each output block
OTYPE  out  2  BTYPE of the block being output
OTOTAL  out  5  count of nonzero coefficients in the block, valid with OFIRST
READYO  in  1  downstream accept
DONE  out  1  both banks empty, no output pending
ERR  out  1  sticky protocol error

Behaviour:
- Reset (RESETN=0) or NEWSLICE=1:
  - All outputs go to 0, except READYI=1 and DONE=1.
  - Both banks are marked empty, occupancy masks are cleared, wbank=0, rbank=0.
  - NEWSLICE also clears ERR.
  - Reset takes priority over any simultaneous strobe.
- Storage per bank: 16 x DW data, 16-bit occupancy mask, 2-bit type, 5-bit nonzero count, full flag.
- READYI is combinational: it is the inverse of bank[wbank].full.
- Write path, VALIDI=1 and READYI=1:
  - data[wbank][ZPOS] <= ZIN and mask bit ZPOS is set.
  - The count increments if ZIN != 0 and the mask bit was clear. A rewrite of the same position overwrites the data and adjusts the count (-1 if old != 0, +1 if new != 0).
  - Position illegal for the pending type (DC: pos > 3; AC: pos 0) sets ERR, is not written, and does not count. The type used for this check is the BTYPE currently on the port.
- BEND=1 with READYI=1:
  - Latch BTYPE, set bank[wbank].full, toggle wbank.
  - A same-cycle VALIDI is written first and is included in the block.
  - BEND with no prior VALIDI gives an all-zero block, which is still emitted.
  - BTYPE=3 sets ERR; the block is emitted as luma.
- VALIDI or BEND while READYI=0: ignored, ERR set.
- Read FSM states:
  - IDLE: go to EMIT when bank[rbank].full. Load the start index (0, or 1 for AC) and the last index (15 for luma and AC, 3 for DC).
  - EMIT: the output register loads when VALIDO=0 or READYO=1.
    - VOUT = mask[idx] ? data[idx] : 0.
    - OFIRST=1 on the start index only; OTYPE and OTOTAL are held for the whole block.
    - When the last index is loaded, clear the bank's full flag and mask, and toggle rbank.
    - Then return to IDLE, or go straight to the next block with no bubble if the other bank is full.
  - With READYO=0, VOUT, VALIDO, OFIRST and OTYPE hold.
- Latency:
  - Minimum: first VALIDO 2 cycles after BEND is accepted (cycle 1 full flag, cycle 2 output register).
  - Throughput: 1 coefficient/cycle with READYO held high.
- A bank freed on cycle N is writable on cycle N+1. No same-cycle write into the bank being drained.
- DONE = both banks empty and VALIDO=0. It goes low the cycle after any accepted VALIDI.
- OTOTAL counts nonzero values actually stored. Zeros written explicitly are not counted.

Test Plan:
1. Luma block, VALIDI at ZPOS 15,3,0 with ZIN 5,-2,7, BEND at the last write, READYO=1 -> 16 VALIDO beats: 7,0,0,-2,0..0,5. OFIRST on beat 1, OTYPE=0, OTOTAL=3, first VALIDO 2 cycles after BEND.
2. Chroma DC, pos 2 = 9, BEND -> 4 beats 0,0,9,0, OTOTAL=1. Chroma AC, pos 1 = -1 -> 15 beats starting with -1, OTYPE=2.
3. Back-to-back: three luma blocks sent with READYO=0 -> READYI drops after the 2nd BEND and the 3rd block's VALIDI is ignored with ERR=1. Then raise READYO -> 32 contiguous beats, and READYI rises the cycle after the first block's last beat.
4. READYO toggling 1010... during emit -> no beat lost or duplicated; VOUT stable while READYO=0.
5. Rewrite pos 4 with 3 then 0 -> output pos 4 = 0, OTOTAL=0. DC write at pos 7 -> ERR=1, pos not stored.
6. RESETN=0 mid-emit (beat 6 of 16) -> next cycle VALIDO=0, DONE=1, READYI=1. A new block after reset emits cleanly with no stale mask bits. NEWSLICE repeats the same check and also clears ERR.
